bin_to_7_seg: RTL and testbench
===============================

// Module: bin_to_7_seg
// PURPOSE
//   Converts a 4-bit binary nibble into the seven segment drives (a..g) of a
//   single hexadecimal digit, glyphs 0-9 and A,b,C,d,E,F.
//   Sits between the datapath (register/ALU value) and the board display.
//   Outputs are registered.
// PARAMETERS
//   none. The segment encoding is fixed: active-high, 1 = segment lit.
// PORTS
//   clk        in   1  single system clock; all state updates on the rising edge
//   rst_n      in   1  asynchronous, active-low reset
//   bin_input  in   4  binary value to display, 0x0..0xF
//   a          out  1  segment a (top)
//   b          out  1  segment b (top right)
//   c          out  1  segment c (bottom right)
//   d          out  1  segment d (bottom)
//   e          out  1  segment e (bottom left)
//   f          out  1  segment f (top left)
//   g          out  1  segment g (middle)
// BEHAVIOUR
//   - Reset: while rst_n = 0, a..g = 0 (display blank), regardless of clk.
//     Reset takes effect immediately on assertion and may occur at any time.
//   - After rst_n deasserts, the first rising clk edge loads the decode of
//     the bin_input value present at that edge.
//   - Latency: exactly 1 cycle. bin_input sampled at edge N appears on a..g
//     after edge N. bin_input changes between edges have no effect.
//   - Decode table. Columns are a b c d e f g; 1 = lit.
//     0:1111110  1:0110000  2:1101101  3:1111001
//     4:0110011  5:1011011  6:1011111  7:1110000
//     8:1111111  9:1111011  A:1110111  b:0011111
//     C:1001110  d:0111101  E:1001111  F:1000111
//   - All 16 codes are legal; there is no invalid or blank input code.
//   - X or Z on bin_input is not required to be handled; the bench drives
//     only 0/1.
//   - There are no handshakes. The output holds its value until the next
//     clock edge or until reset.
// STRUCTURE
//   - Shared package: localparam 7-bit glyph constants SEG_0..SEG_F in
//     {a,b,c,d,e,f,g} order, plus SEG_BLANK = 7'b0000000.
//   - Sub-module seg7_decode: purely combinational. Input is the 4-bit
//     value; output is the 7-bit {a..g} pattern, a case statement over the
//     package constants.
//   - Top level: instantiates seg7_decode and holds one 7-bit output
//     register with async active-low clear. Individual ports a..g are
//     unpacked from that register.
// TESTING
//   1. Assert rst_n=0 mid-cycle with bin_input=8 -> a..g = 0 immediately,
//      with no clk edge needed.
//   2. Release reset, drive bin_input=0, one clk edge -> abcdefg = 1111110.
//   3. Sweep 0x0..0xF, one value per cycle -> each output equals the table
//      entry one cycle later (e.g. 0x2 -> 1101101, 0xB -> 0011111).
//   4. Toggle bin_input 3 -> 5 -> 3 between edges -> the output reflects
//      only the value sampled at the edge (3 -> 1111001).
//   5. Hold bin_input=F for 5 cycles -> output stable at 1000111, no glitch.
//   6. Assert rst_n while displaying 8 -> blank at once. Deassert, next edge
//      with bin_input=8 -> 1111111.

Source files
------------

// File: rtl/bin_to_7_seg_pkg.sv
// Glyph constants for a single active-high hex digit, {a,b,c,d,e,f,g} order.
package bin_to_7_seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_A     = 7'b1110111;
    localparam logic [6:0] SEG_B     = 7'b0011111;
    localparam logic [6:0] SEG_C     = 7'b1001110;
    localparam logic [6:0] SEG_D     = 7'b0111101;
    localparam logic [6:0] SEG_E     = 7'b1001111;
    localparam logic [6:0] SEG_F     = 7'b1000111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble to seven-segment pattern decode.
module seg7_decode
    import bin_to_7_seg_pkg::*;
(
    input  logic [3:0] i_val,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_val)
            4'h0: o_seg = SEG_0;
            4'h1: o_seg = SEG_1;
            4'h2: o_seg = SEG_2;
            4'h3: o_seg = SEG_3;
            4'h4: o_seg = SEG_4;
            4'h5: o_seg = SEG_5;
            4'h6: o_seg = SEG_6;
            4'h7: o_seg = SEG_7;
            4'h8: o_seg = SEG_8;
            4'h9: o_seg = SEG_9;
            4'hA: o_seg = SEG_A;
            4'hB: o_seg = SEG_B;
            4'hC: o_seg = SEG_C;
            4'hD: o_seg = SEG_D;
            4'hE: o_seg = SEG_E;
            4'hF: o_seg = SEG_F;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bin_to_7_seg.sv
// Registered hex digit driver: decode the nibble, latch it, fan out to a..g.
module bin_to_7_seg
    import bin_to_7_seg_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] bin_input,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       e,
    output logic       f,
    output logic       g
);

    logic [6:0] w_seg;
    logic [6:0] r_seg;

    seg7_decode u_decode (
        .i_val (bin_input),
        .o_seg (w_seg)
    );

    // Blank the display the moment reset asserts, independent of clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_seg <= SEG_BLANK;
        else        r_seg <= w_seg;
    end

    assign {a, b, c, d, e, f, g} = r_seg;

endmodule

// File: tb/tb_bin_to_7_seg.sv
// Bench for bin_to_7_seg: directed cases plus random traffic against a table model.
module tb_bin_to_7_seg;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] bin_input = 4'h0;
    logic       a, b, c, d, e, f, g;

    int n_tests = 0;
    int n_fail  = 0;

    bin_to_7_seg dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bin_input (bin_input),
        .a (a), .b (b), .c (c), .d (d), .e (e), .f (f), .g (g)
    );

    always #5 clk = ~clk;

    // Reference: the glyph table, each entry written as the lit segments
    // a..g, built up segment by segment.
    function automatic logic [6:0] glyph(input logic [3:0] v);
        string lit;
        logic [6:0] p;
        case (v)
            4'h0: lit = "abcdef";  4'h1: lit = "bc";
            4'h2: lit = "abdeg";   4'h3: lit = "abcdg";
            4'h4: lit = "bcfg";    4'h5: lit = "acdfg";
            4'h6: lit = "acdefg";  4'h7: lit = "abc";
            4'h8: lit = "abcdefg"; 4'h9: lit = "abcdfg";
            4'hA: lit = "abcefg";  4'hB: lit = "cdefg";
            4'hC: lit = "adef";    4'hD: lit = "bcdeg";
            4'hE: lit = "adefg";   default: lit = "aefg";
        endcase
        p = 7'b0;
        for (int i = 0; i < lit.len(); i++)
            p[6 - (lit[i] - "a")] = 1'b1;
        return p;
    endfunction

    function automatic logic [6:0] segs();
        return {a, b, c, d, e, f, g};
    endfunction

    task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Drive v at the falling edge, clock it in, check 1 ns after the edge.
    task automatic step(input logic [3:0] v, input string tag);
        @(negedge clk);
        bin_input = v;
        @(posedge clk);
        #1;
        chk(tag, segs(), glyph(v));
    endtask

    initial begin
        logic [3:0] cur;

        // Startup reset, then reset asserted mid-cycle while showing 8.
        rst_n = 1'b0;
        #12;
        chk("reset_initial", segs(), 7'b0);
        rst_n = 1'b1;
        step(4'h8, "pre_reset_8");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_async_blank", segs(), 7'b0);
        @(posedge clk);
        #1;
        chk("reset_held_over_edge", segs(), 7'b0);

        // Release, first edge loads bin_input=0.
        @(negedge clk);
        rst_n = 1'b1;
        step(4'h0, "first_after_reset");
        chk("first_after_reset_const", segs(), 7'b1111110);

        // Sweep all codes.
        for (int v = 0; v < 16; v++)
            step(4'(v), $sformatf("sweep_%0h", v));
        step(4'h2, "sweep_2_const");
        chk("glyph_2_const", segs(), 7'b1101101);
        step(4'hB, "sweep_b_const");
        chk("glyph_b_const", segs(), 7'b0011111);

        // Toggle between edges: only the sampled value counts.
        @(negedge clk);
        bin_input = 4'h3;
        #1 bin_input = 4'h5;
        #1 bin_input = 4'h3;
        @(posedge clk);
        #1;
        chk("toggle_sampled_3", segs(), 7'b1111001);
        bin_input = 4'h5;
        #2;
        chk("toggle_hold_mid", segs(), 7'b1111001);
        bin_input = 4'h3;
        @(posedge clk);
        #1;
        chk("toggle_after_edge", segs(), 7'b1111001);

        // Hold F; check every ns across five cycles for glitches.
        @(negedge clk);
        bin_input = 4'hF;
        @(posedge clk);
        #1;
        for (int t = 0; t < 50; t++) begin
            chk("hold_f", segs(), 7'b1000111);
            #1;
        end

        // Reset while showing 8, then release and load 8.
        step(4'h8, "show_8");
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_while_8", segs(), 7'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step(4'h8, "reload_8");
        chk("reload_8_const", segs(), 7'b1111111);

        // Random traffic with mid-cycle noise and occasional resets.
        cur = 4'h8;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 19) == 0) begin
                #1 rst_n = 1'b0;
                #1;
                chk("rand_reset", segs(), 7'b0);
                @(negedge clk);
                rst_n = 1'b1;
            end
            cur = 4'($urandom);
            bin_input = 4'($urandom);
            #2 bin_input = cur;
            @(posedge clk);
            #1;
            chk("rand_decode", segs(), glyph(cur));
            #2 bin_input = 4'($urandom);
            #1;
            chk("rand_hold", segs(), glyph(cur));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
